mem_output_ctrl: RTL and testbench

- Load-side counterpart of the store lane/byte-enable controller.
- Tracks each load issued to the data BRAM port B, waits for the one-cycle BRAM read latency, then extracts the addressed byte, halfword or word from the memory lane order and sign- or zero-extends it for writeback.
- Holds the result stable under pipeline stall, supports flush, and flags misaligned loads.

---
 rtl/mem_output_ctrl_if.sv | 36 +++
 rtl/mem_output_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_output_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_output_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_output_ctrl_if
// Bundles the load-request, BRAM read-data and load-result signals of the
// load-side output controller.
//   memOp[1:0]    request-cycle memory operation
//   memSize[1:0]  request-cycle access size
//   aluIn[31:0]   request-cycle effective address (only [1:0] used)
//   stall         downstream stall
//   flush         discard in-flight and same-cycle load
//   dout[31:0]    BRAM port B read data
//   loadData      formatted load result
//   loadValid     loadData/busErr valid
//   busErr        misaligned / illegal-size load
// Modports: master = pipeline/BRAM side, slave = the controller.
// ---------------------------------------------------------------------------
interface mem_output_ctrl_if;
    logic [1:0]  memOp;
    logic [1:0]  memSize;
    logic [31:0] aluIn;
    logic        stall;
    logic        flush;
    logic [31:0] dout;
    logic [31:0] loadData;
    logic        loadValid;
    logic        busErr;

    modport master (
        output memOp, memSize, aluIn, stall, flush, dout,
        input  loadData, loadValid, busErr
    );

    modport slave (
        input  memOp, memSize, aluIn, stall, flush, dout,
        output loadData, loadValid, busErr
    );
endinterface

// File: rtl/mem_output_ctrl.sv
// ---------------------------------------------------------------------------
// mem_output_ctrl
// Load-side formatter for the data BRAM port B. Tracks an accepted load,
// waits the one-cycle BRAM latency, extracts the addressed byte/halfword/word
// from the memory lane order (offset0 = dout[31:24] ... offset3 = dout[7:0]),
// sign- or zero-extends it, holds it under stall, drops it on flush and flags
// misaligned or illegal-size loads with busErr (loadData forced to 0).
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_output_ctrl_if.slave (request, dout, result signals)
//
// Optional build macro MEM_OUT_REG_EN: adds an output register on
// loadData/loadValid/busErr (latency 2), frozen while stall=1, cleared by
// flush and reset.
// ---------------------------------------------------------------------------
module mem_output_ctrl (
    input  logic               clk,
    input  logic               rst,
    mem_output_ctrl_if.slave   bus
);
    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;
    localparam logic [1:0] BYTE          = 2'b00;
    localparam logic [1:0] HALFWORD      = 2'b01;
    localparam logic [1:0] WORD          = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t      r_state;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_ext;
    logic [31:0] r_hold_data;
    logic        r_hold_err;

    logic        w_accept;
    logic [32:0] w_fmt;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_err;
    logic        w_unused_addr;

    // Returns {err, data}; err=1 forces data to zero.
    function automatic logic [32:0] format_load(
        input logic [31:0] d,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        ext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [32:0] res;
        b   = 8'h00;
        h   = 16'h0000;
        res = {1'b1, 32'h0000_0000};
        case (size)
            BYTE: begin
                case (off)
                    2'd0:    b = d[31:24];
                    2'd1:    b = d[23:16];
                    2'd2:    b = d[15:8];
                    default: b = d[7:0];
                endcase
                res = {1'b0, {24{ext & b[7]}}, b};
            end
            HALFWORD: begin
                case (off)
                    2'd0: begin
                        h   = {d[23:16], d[31:24]};
                        res = {1'b0, {16{ext & h[15]}}, h};
                    end
                    2'd2: begin
                        h   = {d[7:0], d[15:8]};
                        res = {1'b0, {16{ext & h[15]}}, h};
                    end
                    default: res = {1'b1, 32'h0000_0000};
                endcase
            end
            WORD: begin
                if (off == 2'd0) begin
                    res = {1'b0, d[7:0], d[15:8], d[23:16], d[31:24]};
                end else begin
                    res = {1'b1, 32'h0000_0000};
                end
            end
            default: res = {1'b1, 32'h0000_0000};
        endcase
        return res;
    endfunction

    // Only the low address bits select the lane; the rest is intentionally unused.
    assign w_unused_addr = ^bus.aluIn[31:2];

    // Stores and no-ops are never accepted; stall and flush block acceptance.
    assign w_accept = ((bus.memOp == MEM_READ_SEXT) || (bus.memOp == MEM_READ_ZEXT))
                      && !bus.stall && !bus.flush;

    assign w_fmt = format_load(bus.dout, r_off, r_size, r_ext);

    // Load-tracking FSM with request capture and stall hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_off       <= 2'b00;
            r_size      <= 2'b00;
            r_ext       <= 1'b0;
            r_hold_data <= 32'h0000_0000;
            r_hold_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_PEND;
                        r_off   <= bus.aluIn[1:0];
                        r_size  <= bus.memSize;
                        r_ext   <= (bus.memOp == MEM_READ_SEXT);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PEND: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                    end else if (bus.stall) begin
                        // dout is only valid this cycle, so freeze the result now.
                        r_state     <= ST_HOLD;
                        r_hold_data <= w_fmt[31:0];
                        r_hold_err  <= w_fmt[32];
                    end else if (w_accept) begin
                        r_state <= ST_PEND;
                        r_off   <= bus.aluIn[1:0];
                        r_size  <= bus.memSize;
                        r_ext   <= (bus.memOp == MEM_READ_SEXT);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                    end else if (bus.stall) begin
                        r_state <= ST_HOLD;
                    end else if (w_accept) begin
                        r_state <= ST_PEND;
                        r_off   <= bus.aluIn[1:0];
                        r_size  <= bus.memSize;
                        r_ext   <= (bus.memOp == MEM_READ_SEXT);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Result mux: live formatting in PEND, frozen copy in HOLD, zero otherwise.
    always_comb begin
        w_valid = 1'b0;
        w_data  = 32'h0000_0000;
        w_err   = 1'b0;
        case (r_state)
            ST_PEND: begin
                w_valid = 1'b1;
                w_data  = w_fmt[31:0];
                w_err   = w_fmt[32];
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                w_data  = r_hold_data;
                w_err   = r_hold_err;
            end
            default: begin
                w_valid = 1'b0;
                w_data  = 32'h0000_0000;
                w_err   = 1'b0;
            end
        endcase
    end

`ifdef MEM_OUT_REG_EN
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_err;

    // Output register: flush drops the result, stall freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= 32'h0000_0000;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (bus.flush) begin
            r_out_data  <= 32'h0000_0000;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (bus.stall) begin
            r_out_data  <= r_out_data;
            r_out_valid <= r_out_valid;
            r_out_err   <= r_out_err;
        end else begin
            r_out_data  <= w_data;
            r_out_valid <= w_valid;
            r_out_err   <= w_err;
        end
    end

    assign bus.loadData  = r_out_data;
    assign bus.loadValid = r_out_valid;
    assign bus.busErr    = r_out_err;
`else
    assign bus.loadData  = w_data;
    assign bus.loadValid = w_valid;
    assign bus.busErr    = w_err;
`endif

endmodule

// File: tb/tb_mem_output_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_output_ctrl
// Directed and randomized checks of mem_output_ctrl (default build) against a
// behavioural load-formatting model kept in the bench.
// ---------------------------------------------------------------------------
module tb_mem_output_ctrl;
    logic clk;
    logic rst;

    mem_output_ctrl_if bus ();

    mem_output_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] D = 32'h8A7F01FE;

    int vectors = 0;
    int miscompares = 0;

    // Model: a load whose data arrives this cycle, and/or a frozen result.
    bit          m_known = 0;
    bit          m_pend_v = 0;
    logic [1:0]  m_pend_off = 2'b00;
    logic [1:0]  m_pend_sz = 2'b00;
    bit          m_pend_ext = 0;
    bit          m_held_v = 0;
    logic [32:0] m_held = 33'h0;

    // Pick the bytes at off..off+n-1 (lane order), assemble little-endian, extend.
    function automatic logic [32:0] m_fmt(input logic [31:0] d, input logic [1:0] off_l,
                                          input logic [1:0] sz_l, input bit ext);
        int off;
        int n;
        logic [63:0] v;
        off = int'(off_l);
        n = (sz_l == 2'b00) ? 1 : (sz_l == 2'b01) ? 2 : (sz_l == 2'b10) ? 4 : 0;
        if (n == 0 || (off % n) != 0) return {1'b1, 32'h0};
        v = 64'h0;
        for (int i = 0; i < n; i++) v = v | (64'(d[31 - 8*(off+i) -: 8]) << (8*i));
        if (ext && v[8*n-1]) v = v | ~((64'h1 << (8*n)) - 64'h1);
        return {1'b0, v[31:0]};
    endfunction

    task automatic pin(input string name, input logic [32:0] got, input logic [32:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL model_%s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic lit(input string name, input logic v, input logic [31:0] d, input logic e);
        vectors++;
        if (bus.loadValid !== v || bus.loadData !== d || bus.busErr !== e) begin
            miscompares++;
            $display("FAIL %s: got valid=%b data=%h err=%b required valid=%b data=%h err=%b",
                     name, bus.loadValid, bus.loadData, bus.busErr, v, d, e);
        end
    endtask

    // Compare DUT against model for this cycle, then advance the model.
    task automatic check_and_advance();
        logic        ev;
        logic [32:0] er;
        bit          acc;
        ev = 1'b0;
        er = 33'h0;
        if (m_pend_v) begin
            ev = 1'b1;
            er = m_fmt(bus.dout, m_pend_off, m_pend_sz, m_pend_ext);
        end else if (m_held_v) begin
            ev = 1'b1;
            er = m_held;
        end
        if (m_known) begin
            vectors++;
            if (bus.loadValid !== ev || bus.loadData !== er[31:0] || bus.busErr !== er[32]) begin
                miscompares++;
                $display("FAIL cycle_t%0t: got valid=%b data=%h err=%b required valid=%b data=%h err=%b",
                         $time, bus.loadValid, bus.loadData, bus.busErr, ev, er[31:0], er[32]);
            end
        end
        acc = (bus.memOp == 2'b01 || bus.memOp == 2'b10) && !bus.stall && !bus.flush;
        if (rst) begin
            m_known = 1; m_pend_v = 0; m_held_v = 0;
        end else if (bus.flush) begin
            m_pend_v = 0; m_held_v = 0;
        end else if (bus.stall) begin
            if (ev) begin
                m_held_v = 1; m_held = er; m_pend_v = 0;
            end
        end else begin
            m_held_v = 0;
            m_pend_v = acc;
            m_pend_off = bus.aluIn[1:0];
            m_pend_sz = bus.memSize;
            m_pend_ext = (bus.memOp == 2'b01);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] op, input logic [1:0] sz,
                        input logic [1:0] off, input logic st, input logic fl,
                        input logic [31:0] d);
        logic [31:0] rnd;
        @(posedge clk);
        #1;
        rnd = $urandom();
        rst = r;
        bus.memOp = op;
        bus.memSize = sz;
        bus.aluIn = {rnd[31:2], off};
        bus.stall = st;
        bus.flush = fl;
        bus.dout = d;
        @(negedge clk);
        check_and_advance();
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1'b1;
        bus.memOp = 2'b00; bus.memSize = 2'b00; bus.aluIn = 32'h0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.dout = 32'h0;

        // Pin the model with hand-computed values.
        pin("lb0",  m_fmt(D, 2'd0, 2'b00, 1'b1), {1'b0, 32'hFFFFFF8A});
        pin("lbu1", m_fmt(D, 2'd1, 2'b00, 1'b0), {1'b0, 32'h0000007F});
        pin("lh2",  m_fmt(D, 2'd2, 2'b01, 1'b1), {1'b0, 32'hFFFFFE01});
        pin("lhu0", m_fmt(D, 2'd0, 2'b01, 1'b0), {1'b0, 32'h00007F8A});
        pin("lw0",  m_fmt(D, 2'd0, 2'b10, 1'b1), {1'b0, 32'hFE017F8A});
        pin("lh1",  m_fmt(D, 2'd1, 2'b01, 1'b1), {1'b1, 32'h0});

        step(1'b1, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0);
        lit("reset_idle", 1'b0, 32'h0, 1'b0);

        // Byte loads.
        step(1'b0, 2'b01, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 2'b10, 2'b00, 2'd1, 1'b0, 1'b0, D);
        lit("lb_off0", 1'b1, 32'hFFFFFF8A, 1'b0);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, D);
        lit("lbu_off1", 1'b1, 32'h0000007F, 1'b0);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, D);
        lit("idle_after_byte", 1'b0, 32'h0, 1'b0);

        // Back-to-back halfword / word.
        step(1'b0, 2'b01, 2'b01, 2'd2, 1'b0, 1'b0, D);
        step(1'b0, 2'b10, 2'b01, 2'd0, 1'b0, 1'b0, D);
        lit("lh_off2", 1'b1, 32'hFFFFFE01, 1'b0);
        step(1'b0, 2'b01, 2'b10, 2'd0, 1'b0, 1'b0, D);
        lit("lhu_off0", 1'b1, 32'h00007F8A, 1'b0);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, D);
        lit("lw", 1'b1, 32'hFE017F8A, 1'b0);

        // Misaligned / illegal size.
        step(1'b0, 2'b01, 2'b01, 2'd1, 1'b0, 1'b0, D);
        step(1'b0, 2'b01, 2'b10, 2'd2, 1'b0, 1'b0, D);
        lit("lh_off1_err", 1'b1, 32'h0, 1'b1);
        step(1'b0, 2'b10, 2'b11, 2'd0, 1'b0, 1'b0, D);
        lit("lw_off2_err", 1'b1, 32'h0, 1'b1);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, D);
        lit("size3_err", 1'b1, 32'h0, 1'b1);

        // Stall hold while dout goes to zero; request during stall ignored.
        step(1'b0, 2'b01, 2'b10, 2'd0, 1'b0, 1'b0, D);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b1, 1'b0, D);
        lit("stall_c1", 1'b1, 32'hFE017F8A, 1'b0);
        step(1'b0, 2'b01, 2'b00, 2'd1, 1'b1, 1'b0, 32'h0);
        lit("stall_c2", 1'b1, 32'hFE017F8A, 1'b0);
        step(1'b0, 2'b01, 2'b00, 2'd2, 1'b1, 1'b0, 32'h0);
        lit("stall_c3", 1'b1, 32'hFE017F8A, 1'b0);
        step(1'b0, 2'b10, 2'b00, 2'd3, 1'b0, 1'b0, 32'h0);
        lit("stall_release", 1'b1, 32'hFE017F8A, 1'b0);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, D);
        lit("after_release", 1'b1, 32'h000000FE, 1'b0);

        // Flush beats stall and a new request.
        step(1'b0, 2'b01, 2'b00, 2'd0, 1'b0, 1'b0, D);
        step(1'b0, 2'b01, 2'b10, 2'd0, 1'b1, 1'b1, D);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, D);
        lit("after_flush", 1'b0, 32'h0, 1'b0);

        // Reset for two cycles mid-PEND.
        step(1'b0, 2'b01, 2'b10, 2'd0, 1'b0, 1'b0, D);
        step(1'b1, 2'b01, 2'b10, 2'd0, 1'b0, 1'b0, D);
        step(1'b1, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, D);
        lit("reset_mid_pend", 1'b0, 32'h0, 1'b0);
        step(1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, D);
        lit("after_reset", 1'b0, 32'h0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rd = $urandom();
            step((rd[31:25] == 7'd0),
                 rd[1:0], rd[3:2], rd[5:4],
                 (rd[7:6] == 2'b00),
                 (rd[11:8] == 4'd0),
                 $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
